// File: rtl/stream_mux_pkg.sv
// Shared types and default parameters for the round-robin/fixed stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {MODE_FIXED, MODE_RR} mode_e;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/stream_mux_rr_pick.sv
// Rotating-priority picker: grants the first requester at or above ptr, wrapping at N-1.
module rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = W'((32'(ptr) + k) % $unsigned(N));
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with registered output, fixed or round-robin select,
// and a wrapping count of accepted input beats.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mode,
    input  logic [CH_W-1:0]             sel,
    input  logic [N_CH-1:0]             in_valid,
    input  logic [N_CH-1:0][WIDTH-1:0]  in_data,
    output logic [N_CH-1:0]             in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    output logic [CH_W-1:0]             out_ch,
    input  logic                        out_ready,
    output logic [CNT_W-1:0]            beat_cnt
);

    logic            can_load;
    logic            grant_valid;
    logic [CH_W-1:0] grant;
    logic            rr_valid;
    logic [CH_W-1:0] rr_idx;
    logic [CH_W-1:0] rr_ptr;
    logic            xfer;
    logic            is_rr;

    assign is_rr    = (mode_e'(mode) == MODE_RR);
    assign can_load = !out_valid || out_ready;

    rr_pick #(.N(N_CH), .W(CH_W)) u_pick (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // Fixed mode looks only at in_valid[sel], so other producers cannot influence its grant.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        if (is_rr) begin
            grant_valid = rr_valid;
            grant       = rr_idx;
        end else if ((32'(sel) < $unsigned(N_CH)) && in_valid[sel]) begin
            grant_valid = 1'b1;
            grant       = sel;
        end
    end

    always_comb begin
        in_ready = '0;
        if (!rst && can_load && grant_valid) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign xfer = |(in_valid & in_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant];
                out_ch    <= grant;
                beat_cnt  <= beat_cnt + CNT_W'(1);
                if (is_rr) begin
                    rr_ptr <= CH_W'((32'(grant) + 32'd1) % $unsigned(N_CH));
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Randomized scoreboard bench for stream_mux_rr against a cycle-level behavioural model.
module tb_stream_mux_rr;

    localparam int N_CH  = 4;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int CH_W  = 2;
    localparam int NCYC  = 4000;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       mode = 1'b0;
    logic [CH_W-1:0]            sel = '0;
    logic [N_CH-1:0]            in_valid = '0;
    logic [N_CH-1:0][WIDTH-1:0] in_data = '0;
    logic [N_CH-1:0]            in_ready;
    logic                       out_valid;
    logic [WIDTH-1:0]           out_data;
    logic [CH_W-1:0]            out_ch;
    logic                       out_ready = 1'b1;
    logic [CNT_W-1:0]           beat_cnt;

    int tests = 0;
    int fails = 0;

    // Expected beats in acceptance order: {channel, data}
    logic [CH_W+WIDTH-1:0] sb[$];

    always #5 clk = ~clk;

    stream_mux_rr #(.N_CH(N_CH), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready),
        .beat_cnt  (beat_cnt)
    );

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: consumes every beat the DUT hands downstream and matches it against the queue.
    initial begin
        logic [CH_W+WIDTH-1:0] e;
        forever begin
            @(posedge clk);
            #8;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_ch", int'(out_ch), int'(e[CH_W+WIDTH-1:WIDTH]));
                    check("out_data", int'(out_data), int'(e[WIDTH-1:0]));
                end
            end
        end
    end

    // Driver plus behavioural model
    initial begin
        int  m_ov = 0, m_cnt = 0, m_ptr = 0;
        int  n_ov = 0, n_cnt = 0, n_ptr = 0;
        bit  was_rst = 1'b0;
        bit  gv;
        int  g;
        int  exp_ready;
        bit  can_load;
        int  drain;

        for (int cyc = 0; cyc < NCYC + 6; cyc++) begin
            @(posedge clk);
            #1;
            m_ov = n_ov; m_cnt = n_cnt; m_ptr = n_ptr;
            check("out_valid", int'(out_valid), m_ov);
            check("beat_cnt", int'(beat_cnt), m_cnt);
            if (was_rst) begin
                check("rst_out_data", int'(out_data), 0);
                check("rst_out_ch", int'(out_ch), 0);
            end

            #1;
            if (cyc < 2) begin
                rst = 1'b1; in_valid = '1; out_ready = 1'b1; mode = 1'b1;
            end else if (cyc >= NCYC) begin
                rst = 1'b0; in_valid = '0; out_ready = 1'b1;
            end else begin
                rst = ($urandom_range(99) < 2);
                if ($urandom_range(99) < 6) mode = ~mode;
                if ($urandom_range(99) < 10) sel = CH_W'($urandom_range(N_CH - 1));
                case ($urandom_range(3))
                    0:       in_valid = '1;
                    1:       in_valid = 4'b1001;
                    default: in_valid = N_CH'($urandom);
                endcase
                for (int c = 0; c < N_CH; c++) in_data[c] = WIDTH'($urandom);
                out_ready = ($urandom_range(99) < 70);
            end
            if (rst) sb.delete();
            was_rst = rst;

            #5;
            can_load = (m_ov == 0) || out_ready;
            gv = 1'b0; g = 0;
            if (mode) begin
                for (int k = 0; k < N_CH; k++) begin
                    if (!gv && in_valid[(m_ptr + k) % N_CH]) begin
                        gv = 1'b1; g = (m_ptr + k) % N_CH;
                    end
                end
            end else if (in_valid[sel]) begin
                gv = 1'b1; g = int'(sel);
            end
            exp_ready = (!rst && can_load && gv) ? (1 << g) : 0;
            check("in_ready", int'(in_ready), exp_ready);

            if (rst) begin
                n_ov = 0; n_cnt = 0; n_ptr = 0;
            end else if (can_load && gv) begin
                sb.push_back({CH_W'(g), in_data[g]});
                n_ov = 1;
                n_cnt = (m_cnt + 1) % (1 << CNT_W);
                n_ptr = mode ? (g + 1) % N_CH : m_ptr;
            end else begin
                n_ov = out_ready ? 0 : m_ov;
                n_cnt = m_cnt; n_ptr = m_ptr;
            end
        end

        drain = 0;
        while (sb.size() != 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        check("queue_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
